// File: rtl/bs_drvr_fifo_agent.sv
// bs_drvr_fifo_agent
//   Driver-side end of the parallel bus generator/arbiter protocol
//   (pndng/pop/push/D_pop/D_push). There is one instance per node.
//   - TX FIFO: the local node writes packets into it. The head packet is
//     offered to the arbiter on pndng_bus/D_pop_bus and retires on pop_bus.
//   - RX FIFO: keeps every bus push addressed to this node (own id or
//     broadcast) until the local node consumes it.
//   Both FIFOs are first-word-fall-through. Full and empty are derived from
//   registered occupancy counts, so pop_bus/push_bus never reach pndng_bus,
//   tx_ready or rx_valid combinationally.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   pndng_bus    out  TX FIFO non-empty
//   pop_bus      in   arbiter retires the TX head
//   D_pop_bus    out  TX head packet (zero while pndng_bus=0)
//   push_bus     in   arbiter delivers D_push_bus to this node
//   D_push_bus   in   pushed packet, destination id in the top byte
//   tx_valid     in   local write request
//   tx_data      in   local write data
//   tx_ready     out  TX FIFO not full
//   rx_valid     out  RX FIFO non-empty
//   rx_data      out  RX head packet
//   rx_ready     in   local consume of the RX head
//   tx_count     out  TX occupancy
//   rx_count     out  RX occupancy
//   rx_overflow  out  sticky: a matching push was dropped because RX was full
//   pop_err      out  sticky: pop_bus arrived while pndng_bus=0
`timescale 1ns/1ps

module bs_drvr_fifo_agent #(
  parameter int          bits      = 256,
  parameter int          depth     = 16,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       pndng_bus,
  input  logic                       pop_bus,
  output logic [bits-1:0]            D_pop_bus,
  input  logic                       push_bus,
  input  logic [bits-1:0]            D_push_bus,
  input  logic                       tx_valid,
  input  logic [bits-1:0]            tx_data,
  output logic                       tx_ready,
  output logic                       rx_valid,
  output logic [bits-1:0]            rx_data,
  input  logic                       rx_ready,
  output logic [$clog2(depth):0]     tx_count,
  output logic [$clog2(depth):0]     rx_count,
  output logic                       rx_overflow,
  output logic                       pop_err
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // TX FIFO state
  logic [bits-1:0] tx_mem [depth];
  logic [AW-1:0]   tx_wr_ptr;
  logic [AW-1:0]   tx_rd_ptr;
  logic [CW-1:0]   tx_cnt;
  logic            tx_wr;
  logic            tx_rd;

  // RX FIFO state
  logic [bits-1:0] rx_mem [depth];
  logic [AW-1:0]   rx_wr_ptr;
  logic [AW-1:0]   rx_rd_ptr;
  logic [CW-1:0]   rx_cnt;
  logic [7:0]      rx_dest;
  logic            rx_match;
  logic            rx_full;
  logic            rx_wr;
  logic            rx_rd;

  // Handshake flags come only from registered counts; a same-cycle pop never
  // opens room for a write, and a same-cycle consume never rescues a push.
  assign tx_ready  = (tx_cnt != FULL_CNT);
  assign pndng_bus = (tx_cnt != '0);
  assign tx_wr     = tx_valid && tx_ready;
  assign tx_rd     = pop_bus && pndng_bus;
  assign D_pop_bus = pndng_bus ? tx_mem[tx_rd_ptr] : '0;
  assign tx_count  = tx_cnt;

  assign rx_dest   = D_push_bus[bits-1 -: 8];
  assign rx_match  = (rx_dest == id) || (rx_dest == broadcast);
  assign rx_full   = (rx_cnt == FULL_CNT);
  assign rx_valid  = (rx_cnt != '0);
  assign rx_wr     = push_bus && rx_match && !rx_full;
  assign rx_rd     = rx_valid && rx_ready;
  assign rx_data   = rx_mem[rx_rd_ptr];
  assign rx_count  = rx_cnt;

  // Storage arrays are deliberately left out of reset; only pointers and
  // counts define which entries are live.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wr_ptr] <= tx_data;
    if (rx_wr) rx_mem[rx_wr_ptr] <= D_push_bus;
  end

  // TX pointers, occupancy and the sticky pop-while-empty flag.
  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      pop_err   <= 1'b0;
    end else begin
      if (tx_wr) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_rd) tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_wr, tx_rd})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (pop_bus && !pndng_bus) pop_err <= 1'b1;
    end
  end

  // RX pointers, occupancy and the sticky overflow flag. Pushes for other
  // nodes are dropped silently; only a matching push into a full FIFO flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_cnt      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_wr) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_rd) rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_wr, rx_rd})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (push_bus && rx_match && rx_full) rx_overflow <= 1'b1;
    end
  end

endmodule
